// File: rtl/xcvr_pkg.sv
// Shared types, default parameters and helpers for the tristate bus transceiver.
package xcvr_pkg;

  localparam int unsigned XCVR_DATA_W     = 6;
  localparam int unsigned XCVR_DRIVE_CYC  = 2;
  localparam int unsigned XCVR_TURN_CYC   = 1;
  localparam int unsigned XCVR_SAMPLE_CYC = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    TURN   = 3'd2,
    SAMPLE = 3'd3,
    RESP   = 3'd4
  } xcvr_state_t;

  // Counter width able to hold the largest of the three reload values.
  function automatic int unsigned cnt_w(input int unsigned a,
                                        input int unsigned b,
                                        input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return int'($clog2(m + 1));
  endfunction

endpackage

// File: rtl/tristate_bus_xcvr.sv
// Converts a valid/ready command stream into timed writes/reads on a shared
// tristate bus, with a guaranteed high-Z turnaround after every write.
module tristate_bus_xcvr
  import xcvr_pkg::*;
#(
  parameter int unsigned DATA_W     = XCVR_DATA_W,
  parameter int unsigned DRIVE_CYC  = XCVR_DRIVE_CYC,
  parameter int unsigned TURN_CYC   = XCVR_TURN_CYC,
  parameter int unsigned SAMPLE_CYC = XCVR_SAMPLE_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  inout  wire logic [DATA_W-1:0] bus,
  output logic              bus_oe,
  output logic              busy
);

  localparam int unsigned CW = cnt_w(DRIVE_CYC, TURN_CYC, SAMPLE_CYC);

  // Zero-length phases would break the timing guarantees; refuse to elaborate.
  if (DRIVE_CYC < 1 || TURN_CYC < 1 || SAMPLE_CYC < 1) begin : g_bad_cfg
    $error("tristate_bus_xcvr: DRIVE_CYC, TURN_CYC and SAMPLE_CYC must be >= 1");
  end

  xcvr_state_t       state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] drv_q, drv_d;
  logic              oe_d;
  logic              rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_d;
  logic              cmd_ready_d;
  logic              busy_d;

  // Only registered state reaches the pads.
  assign bus = bus_oe ? drv_q : {DATA_W{1'bz}};

  // Next-state and next-output decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    drv_d       = drv_q;
    oe_d        = bus_oe;
    rsp_valid_d = rsp_valid;
    rsp_data_d  = rsp_data;

    case (state_q)
      IDLE: begin
        oe_d = 1'b0;
        if (cmd_valid) begin
          if (cmd_write) begin
            drv_d   = cmd_data;
            oe_d    = 1'b1;
            cnt_d   = CW'(DRIVE_CYC - 1);
            state_d = DRIVE;
          end else begin
            cnt_d   = CW'(SAMPLE_CYC - 1);
            state_d = SAMPLE;
          end
        end
      end
      DRIVE: begin
        if (cnt_q == '0) begin
          oe_d    = 1'b0;
          cnt_d   = CW'(TURN_CYC - 1);
          state_d = TURN;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      TURN: begin
        oe_d = 1'b0;
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      SAMPLE: begin
        oe_d = 1'b0;
        if (cnt_q == '0) begin
          rsp_data_d  = bus;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        oe_d = 1'b0;
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        oe_d        = 1'b0;
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase

    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  // State and output registers; reset releases the bus immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      drv_q     <= '0;
      bus_oe    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      drv_q     <= drv_d;
      bus_oe    <= oe_d;
      rsp_valid <= rsp_valid_d;
      rsp_data  <= rsp_data_d;
      cmd_ready <= cmd_ready_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_tristate_bus_xcvr.sv
// Self-checking bench for tristate_bus_xcvr with a pulled-down far-end partner.
module tb_tristate_bus_xcvr;

  localparam int unsigned DW = 6;
  localparam int unsigned DC = 2;
  localparam int unsigned TC = 1;
  localparam int unsigned SC = 2;
  localparam int          TIMEOUT = 100;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_write = 1'b0;
  logic [DW-1:0] cmd_data = '0;
  logic          rsp_ready = 1'b0;
  logic          cmd_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          bus_oe;
  logic          busy;

  // Far end of the bus: its own tristate driver plus a weak pull to zero.
  tri0 [DW-1:0]  bus;
  logic          part_oe = 1'b0;
  logic [DW-1:0] part_drv = '0;
  assign bus = part_oe ? part_drv : {DW{1'bz}};

  int tests_run    = 0;
  int tests_failed = 0;
  int contention   = 0;

  tristate_bus_xcvr #(
    .DATA_W(DW), .DRIVE_CYC(DC), .TURN_CYC(TC), .SAMPLE_CYC(SC)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .bus(bus), .bus_oe(bus_oe), .busy(busy)
  );

  always #5 clk = ~clk;

  // Count any cycle in which both ends drive the bus.
  always @(negedge clk) if (bus_oe === 1'b1 && part_oe) contention++;

  // Present a command and return just after the edge that accepts it.
  task automatic send(input logic w, input logic [DW-1:0] d, output bit ok);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = w; cmd_data = d;
    while (cmd_ready !== 1'b1 && n < TIMEOUT) begin @(negedge clk); n++; end
    ok = (n < TIMEOUT);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_data  = DW'($urandom);
  endtask

  // Write accepted at edge T: driven T+1..T+DC, released for TC, ready at T+DC+TC+1.
  task automatic do_write(input logic [DW-1:0] d);
    bit ok;
    logic          e_oe, e_rdy;
    logic [DW-1:0] e_bus;
    send(1'b1, d, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL write_accept timeout"); return; end
    for (int k = 1; k <= int'(DC + TC + 1); k++) begin
      @(negedge clk);
      e_oe  = (k <= int'(DC));
      e_bus = e_oe ? d : '0;
      e_rdy = (k == int'(DC + TC + 1));
      tests_run++;
      if (bus_oe !== e_oe || bus !== e_bus || cmd_ready !== e_rdy || rsp_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL write_cycle k=%0d: oe=%b bus=%h rdy=%b rv=%b, want oe=%b bus=%h rdy=%b rv=0",
                 k, bus_oe, bus, cmd_ready, rsp_valid, e_oe, e_bus, e_rdy);
      end
    end
  endtask

  // Read with partner driving v; response held bp cycles; optional ignored command during the hold.
  task automatic do_read(input logic [DW-1:0] v, input int bp, input bit poke);
    bit ok;
    part_oe = 1'b1; part_drv = v;
    send(1'b0, DW'($urandom), ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL read_accept timeout"); part_oe = 1'b0; return; end
    for (int k = 1; k <= int'(SC); k++) begin
      @(negedge clk);
      tests_run++;
      if (bus_oe !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL read_wait k=%0d: oe=%b rv=%b rdy=%b, want 0 0 0", k, bus_oe, rsp_valid, cmd_ready);
      end
    end
    @(negedge clk);
    tests_run++;
    if (rsp_valid !== 1'b1 || rsp_data !== v) begin
      tests_failed++;
      $display("FAIL read_rsp: rv=%b data=%h, want rv=1 data=%h", rsp_valid, rsp_data, v);
    end
    part_drv = ~v;
    if (poke) begin cmd_valid = 1'b1; cmd_write = 1'b1; cmd_data = DW'($urandom); end
    for (int b = 0; b < bp; b++) begin
      @(negedge clk);
      tests_run++;
      if (rsp_valid !== 1'b1 || rsp_data !== v || cmd_ready !== 1'b0 || bus_oe !== 1'b0) begin
        tests_failed++;
        $display("FAIL rsp_hold b=%0d: rv=%b data=%h rdy=%b oe=%b, want 1 %h 0 0",
                 b, rsp_valid, rsp_data, cmd_ready, bus_oe, v);
      end
    end
    cmd_valid = 1'b0;
    part_oe   = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    tests_run++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL rsp_done: rv=%b rdy=%b busy=%b, want 0 1 0", rsp_valid, cmd_ready, busy);
    end
  endtask

  task automatic test_reset();
    #3 rst = 1'b1;
    #1;
    tests_run++;
    if (bus_oe !== 1'b0 || bus !== '0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0 ||
        busy !== 1'b0 || rsp_data !== '0) begin
      tests_failed++;
      $display("FAIL reset: oe=%b bus=%h rdy=%b rv=%b busy=%b data=%h, want 0 00 1 0 0 00",
               bus_oe, bus, cmd_ready, rsp_valid, busy, rsp_data);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_write();
    do_write(6'h2A);
    repeat (3) do_write(DW'($urandom));
  endtask

  task automatic test_read();
    do_read(6'h15, 0, 1'b0);
    repeat (3) do_read(DW'($urandom), 0, 1'b0);
  endtask

  task automatic test_backpressure();
    do_read(DW'($urandom), 5, 1'b1);
    do_read(DW'($urandom), int'($urandom_range(1, 8)), 1'b1);
  endtask

  // Write then read with cmd_valid held: read accepted only once the turnaround is over.
  task automatic test_back_to_back();
    bit ok;
    logic [DW-1:0] v;
    logic e_oe, e_rdy;
    v = 6'h2B;
    contention = 0;
    send(1'b1, 6'h3F, ok);
    cmd_valid = 1'b1; cmd_write = 1'b0;
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL b2b_accept timeout"); cmd_valid = 1'b0; return; end
    for (int k = 1; k <= int'(DC + TC + 1); k++) begin
      @(negedge clk);
      e_oe  = (k <= int'(DC));
      e_rdy = (k == int'(DC + TC + 1));
      tests_run++;
      if (bus_oe !== e_oe || cmd_ready !== e_rdy || (e_oe && bus !== 6'h3F) || $isunknown(bus)) begin
        tests_failed++;
        $display("FAIL b2b_write k=%0d: oe=%b rdy=%b bus=%h, want oe=%b rdy=%b", k, bus_oe, cmd_ready, bus, e_oe, e_rdy);
      end
    end
    part_oe = 1'b1; part_drv = v;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int k = 1; k <= int'(SC); k++) begin
      @(negedge clk);
      tests_run++;
      if (bus_oe !== 1'b0 || cmd_ready !== 1'b0 || rsp_valid !== 1'b0 || $isunknown(bus)) begin
        tests_failed++;
        $display("FAIL b2b_read k=%0d: oe=%b rdy=%b rv=%b bus=%h", k, bus_oe, cmd_ready, rsp_valid, bus);
      end
    end
    @(negedge clk);
    tests_run++;
    if (rsp_valid !== 1'b1 || rsp_data !== v) begin
      tests_failed++;
      $display("FAIL b2b_rsp: rv=%b data=%h, want 1 %h", rsp_valid, rsp_data, v);
    end
    part_oe = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    tests_run++;
    if (contention != 0) begin
      tests_failed++;
      $display("FAIL b2b_contention: %0d cycles, want 0", contention);
    end
  endtask

  // Reset during a write drive and during a pending response.
  task automatic test_rst_mid_op();
    bit ok;
    send(1'b1, 6'h0C, ok);
    #2;
    tests_run++;
    if (!ok || bus_oe !== 1'b1 || bus !== 6'h0C) begin
      tests_failed++;
      $display("FAIL rst_pre_drive: ok=%b oe=%b bus=%h, want 1 1 0c", ok, bus_oe, bus);
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if (bus_oe !== 1'b0 || bus !== '0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_drive: oe=%b bus=%h busy=%b rdy=%b, want 0 00 0 1", bus_oe, bus, busy, cmd_ready);
    end
    @(negedge clk) rst = 1'b0;
    do_read(6'h33, 0, 1'b0);
    part_oe = 1'b1; part_drv = 6'h1E;
    send(1'b0, '0, ok);
    repeat (SC + 1) @(negedge clk);
    part_oe = 1'b0;
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      tests_run++;
      if (rsp_valid !== 1'b0 || rsp_data !== '0 || cmd_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL rst_resp k=%0d: rv=%b data=%h rdy=%b, want 0 00 1", k, rsp_valid, rsp_data, cmd_ready);
      end
    end
  endtask

  // Random mix of operations, idle gaps and backpressure.
  task automatic test_random();
    contention = 0;
    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if ($urandom_range(0, 1) == 1) do_write(DW'($urandom));
      else do_read(DW'($urandom), int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
    end
    tests_run++;
    if (contention != 0) begin
      tests_failed++;
      $display("FAIL random_contention: %0d cycles, want 0", contention);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_backpressure();
    test_back_to_back();
    test_rst_mid_op();
    test_random();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
